// File: rtl/dap_mem_ap.sv
// dap_mem_ap: debug memory access port bridging DP register accesses (CSW/TAR/DRW/BASE) to a bus master.
// Ports:
//   DCLK, APRESET          clock and asynchronous active-high reset
//   DEVICEEN               debug enable from the system
//   DPREQ/DPWRITE/DPADDR/DPWDATA -> DPACK/DPRDATA/DPERR   register access handshake
//   BASEADDR               ROM table base, returned on BASE reads
//   SLVADDR/SLVWDATA/SLVTRANS/SLVWRITE/SLVSIZE -> SLVRDATA/SLVREADY/SLVRESP   bus master side
// Optional feature: define DAP_MEM_AP_TIMEOUT_EN to abort a data phase after TIMEOUT cycles without SLVREADY.
module dap_mem_ap #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              DCLK,
   input  logic              APRESET,
   input  logic              DEVICEEN,
   input  logic              DPREQ,
   input  logic              DPWRITE,
   input  logic [1:0]        DPADDR,
   input  logic [31:0]       DPWDATA,
   output logic              DPACK,
   output logic [31:0]       DPRDATA,
   output logic              DPERR,
   input  logic [31:0]       BASEADDR,
   output logic [ADDR_W-1:0] SLVADDR,
   output logic [31:0]       SLVWDATA,
   output logic [1:0]        SLVTRANS,
   output logic              SLVWRITE,
   output logic [1:0]        SLVSIZE,
   input  logic [31:0]       SLVRDATA,
   input  logic              SLVREADY,
   input  logic              SLVRESP
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
   state_t state, next;
   logic [1:0] size, addrinc;
   logic sticky, acc, drw, drw_ok, to, done;
   logic [ADDR_W-1:0] tar;
   logic [31:0] csw, rd_mux;
   logic [9:0] inc;
   // DPACK in the accept condition stops a still-held DPREQ from being taken twice
   assign acc    = state == IDLE && DPREQ && !DPACK;
   assign drw    = DPADDR == 2'd2;
   assign drw_ok = DEVICEEN && !sticky && size != 2'b11;
   assign done   = SLVREADY || to;
   assign csw    = {23'd0, sticky, state != IDLE, DEVICEEN, addrinc, 2'b00, size};
   assign inc    = SLVSIZE == 2'b00 ? 10'd1 : SLVSIZE == 2'b01 ? 10'd2 : 10'd4;
   assign rd_mux = DPADDR == 2'd0 ? csw : DPADDR == 2'd1 ? 32'(tar) : DPADDR == 2'd3 ? BASEADDR : 32'd0;
`ifdef DAP_MEM_AP_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge DCLK or posedge APRESET)
      if (APRESET) cnt <= '0;
      else if (state == ADDR) cnt <= '0;
      else if (state == DATA && !SLVREADY) cnt <= cnt + 1'b1;
   // fires on the TIMEOUT-th consecutive not-ready data cycle
   assign to = state == DATA && !SLVREADY && cnt == CW'(TIMEOUT - 1);
`else
   assign to = 1'b0;
`endif
   always_ff @(posedge DCLK or posedge APRESET)
      if (APRESET) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE: next = acc && drw && drw_ok ? ADDR : IDLE;
         ADDR: next = DATA;
         DATA: next = done ? RESP : DATA;
         RESP: next = IDLE;
      endcase
   end
   always_comb SLVTRANS = state == ADDR ? 2'b10 : 2'b00;
   always_ff @(posedge DCLK or posedge APRESET)
      if (APRESET) begin
         tar      <= '0;
         size     <= 2'b10;
         addrinc  <= 2'b00;
         sticky   <= 1'b0;
         DPACK    <= 1'b0;
         DPERR    <= 1'b0;
         DPRDATA  <= '0;
         SLVADDR  <= '0;
         SLVWDATA <= '0;
         SLVWRITE <= 1'b0;
         SLVSIZE  <= 2'b10;
      end else begin
         DPACK <= 1'b0;
         if (acc) begin
            DPERR <= 1'b0;
            if (drw && drw_ok) begin
               SLVADDR  <= tar;
               SLVSIZE  <= size;
               SLVWRITE <= DPWRITE;
               SLVWDATA <= DPWDATA;
            end else begin
               // register accesses and refused DRW accesses complete locally
               DPACK <= 1'b1;
               DPERR <= drw;
               if (!DPWRITE && !drw) DPRDATA <= rd_mux;
               if (DPWRITE && DPADDR == 2'd0) begin
                  size    <= DPWDATA[1:0];
                  addrinc <= DPWDATA[5:4];
                  if (DPWDATA[8]) sticky <= 1'b0;
               end
               if (DPWRITE && DPADDR == 2'd1) tar <= DPWDATA[ADDR_W-1:0];
            end
         end
         if (state == DATA && done) begin
            DPERR <= to || SLVRESP;
            if (to || SLVRESP) sticky <= 1'b1;
            else if (addrinc == 2'b01) tar <= {tar[ADDR_W-1:10], tar[9:0] + inc};
            if (SLVREADY && !SLVWRITE) DPRDATA <= SLVRDATA;
         end
         if (state == RESP) DPACK <= 1'b1;
      end
endmodule

// File: tb/tb_dap_mem_ap.sv
// tb_dap_mem_ap: directed self-checking bench for dap_mem_ap with a programmable bus slave.
module tb_dap_mem_ap;
   logic DCLK = 1'b0, APRESET = 1'b1, DEVICEEN = 1'b1;
   logic DPREQ = 1'b0, DPWRITE = 1'b0;
   logic [1:0] DPADDR = 2'd0;
   logic [31:0] DPWDATA = '0, BASEADDR = 32'hE00F_F003;
   logic DPACK, DPERR, SLVWRITE;
   logic [31:0] DPRDATA, SLVWDATA, SLVADDR;
   logic [1:0] SLVTRANS, SLVSIZE;
   logic [31:0] SLVRDATA = '0;
   logic SLVREADY = 1'b0, SLVRESP = 1'b0;
   int n_chk = 0, n_fail = 0;
   int rdy_delay = 0, dcnt = 0, tr_cnt = 0, tr0;
   logic hang = 1'b0, resp_err = 1'b0, in_data = 1'b0, ack_prev = 1'b0;
   logic [31:0] rdata_val = '0, tr_addr = '0, tr_wdata = '0;
   logic [1:0] tr_size = '0;
   logic tr_write = 1'b0;
   logic [31:0] rd;
   logic er;
   int lat, acks;

   dap_mem_ap #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .DCLK(DCLK), .APRESET(APRESET), .DEVICEEN(DEVICEEN),
      .DPREQ(DPREQ), .DPWRITE(DPWRITE), .DPADDR(DPADDR), .DPWDATA(DPWDATA),
      .DPACK(DPACK), .DPRDATA(DPRDATA), .DPERR(DPERR), .BASEADDR(BASEADDR),
      .SLVADDR(SLVADDR), .SLVWDATA(SLVWDATA), .SLVTRANS(SLVTRANS), .SLVWRITE(SLVWRITE),
      .SLVSIZE(SLVSIZE), .SLVRDATA(SLVRDATA), .SLVREADY(SLVREADY), .SLVRESP(SLVRESP)
   );

   always #5 DCLK = ~DCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one DP access from a negedge; returns read data, error and cycles to DPACK
   task automatic dp(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic e, output int l);
      DPREQ = 1'b1; DPWRITE = w; DPADDR = a; DPWDATA = d; l = 0;
      do begin @(negedge DCLK); l++; end while (DPACK !== 1'b1 && l < 40);
      r = DPRDATA; e = DPERR;
      DPREQ = 1'b0;
      @(negedge DCLK);
   endtask

   // bus slave: ready after rdy_delay extra data cycles unless hang
   initial forever begin
      @(negedge DCLK);
      if (APRESET || DPACK) begin in_data = 1'b0; SLVREADY = 1'b0; end
      else if (SLVREADY) begin SLVREADY = 1'b0; in_data = 1'b0; end
      else if (in_data) begin
         dcnt++;
         SLVREADY = !hang && dcnt > rdy_delay;
         SLVRESP = resp_err;
         SLVRDATA = rdata_val;
      end
      if (SLVTRANS === 2'b10) begin in_data = 1'b1; dcnt = 0; end
   end

   always @(negedge DCLK) begin
      if (SLVTRANS === 2'b10) begin
         tr_cnt++; tr_addr = SLVADDR; tr_size = SLVSIZE; tr_write = SLVWRITE; tr_wdata = SLVWDATA;
      end
      if (DPACK === 1'b1) begin
         n_chk++;
         assert (ack_prev !== 1'b1) else begin
            n_fail++;
            $error("FAIL dpack_twice: observed 1 expected 0");
         end
      end
      ack_prev = DPACK;
   end

   initial begin
      repeat (2) @(negedge DCLK);
      chk("rst_trans", SLVTRANS, 2'b00);
      chk("rst_size", SLVSIZE, 2'b10);
      chk("rst_ack", DPACK, 0);
      chk("rst_rdata", DPRDATA, 0);
      APRESET = 1'b0;
      @(negedge DCLK);
      dp(0, 0, 0, rd, er, lat);             chk("csw_rst", rd, 32'h42); chk("csw_lat", lat, 1); chk("csw_err", er, 0);
      dp(1, 0, 32'h12, rd, er, lat);        chk("csw_wr_lat", lat, 1);
      dp(0, 0, 0, rd, er, lat);             chk("csw_12", rd, 32'h52);
      dp(1, 1, 32'h3FC, rd, er, lat);
      dp(0, 1, 0, rd, er, lat);             chk("tar_3fc", rd, 32'h3FC);
      tr0 = tr_cnt;
      dp(1, 2, 32'hA5A5A5A5, rd, er, lat);
      chk("wr_lat", lat, 4); chk("wr_err", er, 0); chk("wr_ntr", tr_cnt - tr0, 1);
      chk("wr_addr", tr_addr, 32'h3FC); chk("wr_size", tr_size, 2'b10);
      chk("wr_dir", tr_write, 1); chk("wr_data", tr_wdata, 32'hA5A5A5A5);
      dp(0, 1, 0, rd, er, lat);             chk("tar_wrap", rd, 32'h0);
      dp(1, 3, 32'h1234, rd, er, lat);
      dp(0, 3, 0, rd, er, lat);             chk("base", rd, 32'hE00FF003); chk("base_err", er, 0);
      dp(1, 1, 32'h100, rd, er, lat);
      rdy_delay = 3; rdata_val = 32'hDEADBEEF;
      dp(0, 2, 0, rd, er, lat);
      chk("rd_lat", lat, 7); chk("rd_data", rd, 32'hDEADBEEF); chk("rd_err", er, 0);
      chk("rd_addr", tr_addr, 32'h100); chk("rd_dir", tr_write, 0);
      rdy_delay = 0;
      dp(0, 1, 0, rd, er, lat);             chk("tar_inc4", rd, 32'h104);
      dp(1, 0, 32'h11, rd, er, lat);
      rdata_val = 32'h1111;
      dp(0, 2, 0, rd, er, lat);             chk("half_size", tr_size, 2'b01); chk("half_data", rd, 32'h1111);
      dp(0, 1, 0, rd, er, lat);             chk("tar_inc2", rd, 32'h106);
      resp_err = 1'b1; rdata_val = 32'h55;
      dp(0, 2, 0, rd, er, lat);             chk("resp_err", er, 1); chk("resp_lat", lat, 4);
      resp_err = 1'b0;
      dp(0, 0, 0, rd, er, lat);             chk("csw_sticky", rd, 32'h151);
      dp(0, 1, 0, rd, er, lat);             chk("tar_hold", rd, 32'h106);
      tr0 = tr_cnt;
      dp(0, 2, 0, rd, er, lat);
      chk("sticky_err", er, 1); chk("sticky_lat", lat, 1); chk("sticky_ntr", tr_cnt - tr0, 0);
      dp(1, 0, 32'h111, rd, er, lat);
      dp(0, 0, 0, rd, er, lat);             chk("csw_clr", rd, 32'h51);
      dp(1, 0, 32'h13, rd, er, lat);
      tr0 = tr_cnt;
      dp(1, 2, 32'h9, rd, er, lat);
      chk("size3_err", er, 1); chk("size3_lat", lat, 1); chk("size3_ntr", tr_cnt - tr0, 0);
      dp(1, 0, 32'h12, rd, er, lat);
      DEVICEEN = 1'b0;
      dp(0, 2, 0, rd, er, lat);
      chk("den_err", er, 1); chk("den_lat", lat, 1); chk("den_ntr", tr_cnt - tr0, 0);
      dp(0, 0, 0, rd, er, lat);             chk("csw_den0", rd, 32'h12);
      DEVICEEN = 1'b1;
`ifdef DAP_MEM_AP_TIMEOUT_EN
      hang = 1'b1;
      dp(0, 2, 0, rd, er, lat);
      chk("to_lat", lat, 7); chk("to_err", er, 1); chk("to_rdata", rd, 32'h12);
      hang = 1'b0;
      dp(0, 0, 0, rd, er, lat);             chk("to_sticky", rd, 32'h152);
      dp(1, 0, 32'h112, rd, er, lat);
`endif
      dp(1, 1, 32'h200, rd, er, lat);
      hang = 1'b1;
      DPREQ = 1'b1; DPWRITE = 1'b1; DPADDR = 2'd2; DPWDATA = 32'h77;
      lat = 0;
      do begin @(negedge DCLK); lat++; end while (SLVTRANS !== 2'b10 && lat < 20);
      chk("rst_seen_addr", SLVTRANS, 2'b10);
      @(negedge DCLK);
      chk("rst_in_data_wdata", SLVWDATA, 32'h77);
      APRESET = 1'b1; DPREQ = 1'b0;
      #1;
      chk("arst_trans", SLVTRANS, 2'b00); chk("arst_addr", SLVADDR, 0);
      chk("arst_wdata", SLVWDATA, 0); chk("arst_write", SLVWRITE, 0);
      chk("arst_size", SLVSIZE, 2'b10); chk("arst_ack", DPACK, 0);
      chk("arst_err", DPERR, 0); chk("arst_rdata", DPRDATA, 0);
      @(negedge DCLK);
      APRESET = 1'b0; hang = 1'b0; acks = 0;
      repeat (8) begin @(negedge DCLK); if (DPACK === 1'b1) acks++; end
      chk("arst_no_ack", acks, 0);
      dp(0, 1, 0, rd, er, lat);             chk("arst_tar", rd, 0);
      dp(0, 0, 0, rd, er, lat);             chk("arst_csw", rd, 32'h42);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dap_mem_ap.md
DAP_MEM_AP -- requirements
Module: dap_mem_ap

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus address width (TAR and SLVADDR width).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum SLVREADY wait cycles before abort.
REQ-003 One clock, DCLK; reset APRESET is asynchronous and active-high.
REQ-004 SHALL provide ports:
- DCLK  in  1  AP clock
- APRESET  in  1  async active-high reset
- DEVICEEN  in  1  debug enabled by system
- DPREQ  in  1  register access request, held until DPACK
- DPWRITE  in  1  write/not read
- DPADDR  in  2  register select: 0 CSW, 1 TAR, 2 DRW, 3 BASE
- DPWDATA  in  32  register write data
- DPACK  out  1  one-cycle completion pulse
- DPRDATA  out  32  read data, valid with DPACK
- DPERR  out  1  access failed, valid with DPACK
- BASEADDR  in  32  ROM table base, read-only via BASE
- SLVADDR  out  ADDR_W  bus address
- SLVWDATA  out  32  bus write data
- SLVTRANS  out  2  2'b10 address phase, 2'b00 otherwise
- SLVWRITE  out  1  bus write/not read
- SLVSIZE  out  2  00 byte, 01 half, 10 word
- SLVRDATA  in  32  bus read data
- SLVREADY  in  1  data phase complete
- SLVRESP  in  1  error response, valid with SLVREADY

Function
REQ-005 CSW fields SHALL be: [1:0] SIZE (RW), [5:4] ADDRINC (RW; 01 = increment, other = off), [6] DEVICEEN (RO), [7] TRINPROG (RO, 1 when FSM not IDLE), [8] STICKYERR (write 1 clears); other bits read 0.
REQ-006 A request SHALL be accepted only in IDLE with DPREQ=1 and DPACK=0; requests while busy are held, not dropped.
REQ-007 CSW, TAR and BASE accesses SHALL assert DPACK exactly one cycle after acceptance, DPERR=0; BASE writes are ignored.
REQ-008 A DRW access SHALL complete with DPACK, DPERR=1 and no bus activity when DEVICEEN=0, STICKYERR=1 or SIZE=11.
REQ-009 FSM states SHALL be IDLE, ADDR, DATA, RESP: IDLE->ADDR on a valid DRW access; ADDR->DATA after one cycle; DATA->RESP on SLVREADY=1 or timeout; RESP->IDLE after one cycle with DPACK=1.
REQ-010 In ADDR, SLVTRANS SHALL be 2'b10 with SLVADDR=TAR, SLVSIZE=SIZE, SLVWRITE=DPWRITE; SLVWDATA=DPWDATA SHALL be held from ADDR through DATA.
REQ-011 In DATA, SLVTRANS SHALL be 2'b00 and SLVADDR/SLVWRITE/SLVSIZE SHALL hold.
REQ-012 On SLVREADY=1 in DATA, a read SHALL capture SLVRDATA into DPRDATA; SLVRESP=1 SHALL set STICKYERR and give DPERR=1 in RESP.
REQ-013 On an error-free DRW completion with ADDRINC=01, TAR SHALL advance by 1/2/4 per SIZE; TAR[9:0] SHALL wrap modulo 1024 with TAR[ADDR_W-1:10] unchanged.
REQ-014 On error or timeout, TAR SHALL not change.
REQ-015 Outside ADDR/DATA, SLVTRANS SHALL be 2'b00; DPACK SHALL never be high two consecutive cycles.

Reset
REQ-016 Asserting APRESET SHALL immediately force: state IDLE, TAR=0, SIZE=10, ADDRINC=00, STICKYERR=0, DPACK=0, DPERR=0, DPRDATA=0, SLVTRANS=00, SLVADDR=0, SLVWDATA=0, SLVWRITE=0, SLVSIZE=10.
REQ-017 Reset during ADDR or DATA SHALL abandon the transfer with no DPACK after release.

Configuration
REQ-018 With DAP_MEM_AP_TIMEOUT_EN defined, a counter SHALL clear on entry to DATA; after TIMEOUT consecutive cycles of SLVREADY=0 the FSM SHALL go to RESP with DPERR=1, STICKYERR set and DPRDATA unchanged.
REQ-019 Without DAP_MEM_AP_TIMEOUT_EN, DATA SHALL wait indefinitely for SLVREADY and no counter logic SHALL exist.

Verification
REQ-020 Write CSW=0x12, TAR=0x3FC, DRW write 0xA5A5A5A5 with SLVREADY=1 -> SLVTRANS=10 at SLVADDR=0x3FC, SLVSIZE=10; TAR then reads 0x000 (1 KB wrap).
REQ-021 Read DRW with SLVREADY delayed 3 cycles, SLVRDATA=0xDEADBEEF -> DPACK 2 cycles after SLVREADY, DPRDATA=0xDEADBEEF, DPERR=0.
REQ-022 DRW access with SLVRESP=1 -> DPERR=1, CSW[8]=1, TAR unchanged; next DRW access errors with no bus activity; CSW write 0x100 clears bit 8.
REQ-023 DEVICEEN=0 or SIZE=11, DRW access -> DPACK next cycle with DPERR=1, SLVTRANS stays 00.
REQ-024 With DAP_MEM_AP_TIMEOUT_EN and TIMEOUT=4, SLVREADY held 0 -> DPERR=1 after 4 DATA cycles, CSW[8]=1.
REQ-025 APRESET pulsed in DATA -> all outputs at reset values same cycle, no DPACK afterwards, TAR reads 0.
